// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared segment index constants, types and the conversion from
//             the multiplexed abcdefgh bus to a static g..a digit pattern.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Bit positions inside a static digit pattern (a = LSB, g = MSB)
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    // Position of the decimal point on the abcdefgh bus
    localparam int SEG_DP = 0;

    typedef logic [6:0] seg7_t;

    typedef struct packed {
        logic  dp;
        seg7_t seg;
    } seg7_dp_t;

    // abcdefgh carries a at the MSB; static digits want a at the LSB
    function automatic seg7_dp_t abcdefgh_to_seg(input logic [7:0] abcdefgh);
        seg7_dp_t r;
        r.seg[SEG_A] = abcdefgh[7];
        r.seg[SEG_B] = abcdefgh[6];
        r.seg[SEG_C] = abcdefgh[5];
        r.seg[SEG_D] = abcdefgh[4];
        r.seg[SEG_E] = abcdefgh[3];
        r.seg[SEG_F] = abcdefgh[2];
        r.seg[SEG_G] = abcdefgh[1];
        r.dp         = abcdefgh[SEG_DP];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_slot.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_digit_slot
//  Brief    : One sticky digit: holds the last captured abcdefgh pattern and
//             counts 1 ms ticks since the last capture to flag staleness.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_slot #(
    parameter int STALE_MS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_capture,
    input  logic       i_tick,
    input  logic [7:0] i_pattern,
    output logic [7:0] o_pattern,
    output logic       o_stale
);

    localparam int                 c_cnt_w   = (STALE_MS < 1) ? 1 : $clog2(STALE_MS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STALE_MS);
    localparam logic [c_cnt_w-1:0] c_cnt_pre = c_cnt_w'(STALE_MS - 1);

    logic [7:0]         r_pattern;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stale;

    // Sticky pattern store: updated only on edges where this digit is selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= '0;
        end else if (i_capture) begin
            r_pattern <= i_pattern;
        end
    end

    // Age counter: capture clears it (and wins over a coincident tick),
    // ticks advance it up to the saturation point where the digit is stale.
    // The stale flag starts set because nothing has been captured yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_stale <= 1'b1;
        end else if (i_capture) begin
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else if (i_tick && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_pre) begin
                r_stale <= 1'b1;
            end
        end
    end

    assign o_pattern = r_pattern;
    assign o_stale   = r_stale;

endmodule
`default_nettype wire

// File: rtl/seg7_dynamic_to_static.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_dynamic_to_static
//  Brief    : Converts the time-multiplexed abcdefgh/digit bus into static
//             per-digit segment drive with PWM dimming, stale-digit blanking
//             and selectable output polarity. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_dynamic_to_static
    import seg7_pkg::*;
#(
    parameter int CLK_MHZ        = 50,
    parameter int W_DIGIT        = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DP_ACTIVE_LOW  = 0,
    parameter int W_BRIGHT       = 4,
    parameter int STALE_MS       = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             abcdefgh,
    input  logic [W_DIGIT-1:0]     digit,
    input  logic [W_BRIGHT-1:0]    brightness,
    input  logic                   stale_blank,
    output logic [W_DIGIT*7-1:0]   seg_out,
    output logic [W_DIGIT-1:0]     dp_out,
    output logic [W_DIGIT-1:0]     stale
);

    localparam int                   c_pre_cnt = CLK_MHZ * 1000;
    localparam int                   c_pre_w   = (c_pre_cnt < 2) ? 1 : $clog2(c_pre_cnt);
    localparam logic [c_pre_w-1:0]   c_pre_max = c_pre_w'(c_pre_cnt - 1);
    // XOR masks turning the internal 1 = lit convention into pin polarity
    localparam logic [W_DIGIT*7-1:0] c_seg_inv = {(W_DIGIT*7){(SEG_ACTIVE_LOW != 0)}};
    localparam logic [W_DIGIT-1:0]   c_dp_inv  = {W_DIGIT{(DP_ACTIVE_LOW != 0)}};

    logic [c_pre_w-1:0]   r_pre;
    logic                 w_tick;
    logic [W_BRIGHT-1:0]  r_pwm;
    logic [W_BRIGHT-1:0]  r_bright;
    logic [W_BRIGHT-1:0]  w_bright_eff;
    logic                 w_pwm_on;
    logic [W_DIGIT*7-1:0] w_seg_next;
    logic [W_DIGIT-1:0]   w_dp_next;

    // 1 ms timebase: single-cycle tick on the cycle the prescaler wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (r_pre == c_pre_max) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = (r_pre == c_pre_max);

    // Free-running PWM phase counter with an explicit wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else if (r_pwm == {W_BRIGHT{1'b1}}) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Brightness is sampled only at the start of a PWM period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bright <= '0;
        end else if (r_pwm == '0) begin
            r_bright <= brightness;
        end
    end

    // In the first slot of a period the freshly sampled value already applies
    assign w_bright_eff = (r_pwm == '0) ? brightness : r_bright;
    assign w_pwm_on     = (&w_bright_eff) || (r_pwm < w_bright_eff);

    for (genvar gi = 0; gi < W_DIGIT; gi++) begin : g_slot
        logic [7:0] w_pattern;
        seg7_dp_t   w_conv;
        logic       w_show;

        seg7_digit_slot #(
            .STALE_MS (STALE_MS)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_capture (digit[gi]),
            .i_tick    (w_tick),
            .i_pattern (abcdefgh),
            .o_pattern (w_pattern),
            .o_stale   (stale[gi])
        );

        assign w_conv                 = abcdefgh_to_seg(w_pattern);
        assign w_show                 = w_pwm_on && !(stale[gi] && stale_blank);
        assign w_seg_next[7*gi +: 7]  = w_show ? w_conv.seg : 7'b0;
        assign w_dp_next[gi]          = w_show & w_conv.dp;
    end

    // Registered, polarity-corrected pin drive; dark at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= c_seg_inv;
            dp_out  <= c_dp_inv;
        end else begin
            seg_out <= w_seg_next ^ c_seg_inv;
            dp_out  <= w_dp_next ^ c_dp_inv;
        end
    end

endmodule
`default_nettype wire
